// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with load, clear, wrap/saturate mode and cascade terminal count.
// Latency: 1 cycle for count/load/clear to z; tc is combinational from z, en and up.
// Backpressure: none; en is level-sensitive and sampled on every rising edge.
module updown_mod_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 10,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] z,
   output logic             tc,
   output logic             ovf
);

   // Highest legal count. Held in WIDTH bits so MODULUS = 2^WIDTH still fits.
   localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             at_boundary;
   logic [WIDTH-1:0] z_next;
   logic             ovf_next;

   // Boundary detection and terminal count; tc ignores clr/load so it can feed the next stage's en.
   always_comb begin
      at_boundary = up ? (z == TOP) : (z == '0);
      tc          = en & at_boundary;
   end

   // Next-state selection in priority order clr > load > en > hold.
   always_comb begin
      z_next   = z;
      ovf_next = 1'b0;
      if (clr) begin
         z_next = '0;
      end else if (load) begin
         // Out-of-range load values clamp to the top count instead of aliasing.
         z_next = (din > TOP) ? TOP : din;
      end else if (en) begin
         if (at_boundary) begin
            // Boundary step always flags ovf; only the wrap mode moves the count.
            ovf_next = 1'b1;
            if (SATURATE == 0) begin
               z_next = up ? '0 : TOP;
            end
         end else begin
            // Away from the boundary, +/-1 can never leave 0..MODULUS-1.
            z_next = up ? (z + ONE) : (z - ONE);
         end
      end
   end

   // State register with synchronous reset overriding all controls.
   always_ff @(posedge clk) begin
      if (rst) begin
         z   <= '0;
         ovf <= 1'b0;
      end else begin
         z   <= z_next;
         ovf <= ovf_next;
      end
   end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter with programmable modulus, wrap or saturate mode, parallel load, synchronous clear and boundary flags. It replaces the fixed 2-bit enable-only counter as the general counting primitive for digit counters, timers and sequencers in lab designs. Multiple instances chain into multi-digit counters through the `tc` output.

## Interface

Parameters:
- `WIDTH`, 4: count register width in bits.
- `MODULUS`, 10: number of count states. The counter counts 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH.
- `SATURATE`, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.

Ports:
- `clk` in 1: clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `clr` in 1: synchronous clear to 0.
- `load` in 1: parallel load of `din`.
- `din` in WIDTH: load value.
- `en` in 1: count enable; one step per cycle while high.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `z` out WIDTH: current count, registered.
- `tc` out 1: terminal count, combinational.
- `ovf` out 1: boundary-event flag, registered one-cycle pulse.

## Operation

Per-edge priority, highest first:
1. `rst`: z=0, ovf=0.
2. `clr`: z=0, ovf=0.
3. `load`: z = din if din ≤ MODULUS-1, otherwise z = MODULUS-1 (clamped). ovf=0.
4. `en`:
   - `up`=1 and z < MODULUS-1: z+1.
   - `up`=0 and z > 0: z-1.
   - Boundary step (up at MODULUS-1, or down at 0):
     - SATURATE=0: z wraps to 0 (up) or to MODULUS-1 (down).
     - SATURATE=1: z holds.
     - ovf=1 in either mode.
   - Non-boundary step: ovf=0.
5. None of the above: z holds, ovf=0.

Rules and boundary cases:
- `tc` = en & ((up & z==MODULUS-1) | (~up & z==0)). It is asserted independent of SATURATE, clr and load, so it can drive the next stage's `en` in a cascade.
- Arithmetic stays within WIDTH bits. z never leaves 0..MODULUS-1, even when MODULUS = 2^WIDTH; no natural binary wrap beyond MODULUS.
- `up` may change on any cycle. Direction reversal at a boundary takes effect immediately; e.g. z=9, up=0, en=1 gives 8 and no ovf.
- `load` and `en` both high: load wins, no step, ovf=0.
- `clr` and `load` both high: clear wins.
- `rst` mid-count overrides everything on that edge. There are no pending events after reset.
- No internal state besides z and ovf.

## Timing

- Reset values: z=0, ovf=0.
- `tc` follows reset only through z (tc = en & ~up after reset).
- Count, load and clear latency: 1 cycle. z shows the new value after the same rising edge that samples the control.
- `ovf` is high for exactly the cycle after a boundary step; it is aligned with the wrapped or held z.
- Continuous enable at the boundary in SATURATE=1 keeps ovf high every cycle.
- `tc` is valid in the same cycle as the inputs. The cascade rule is: next stage `en` = this `tc`. Combined with wrap, this gives a carry ripple of zero cycles latency per stage (combinational chain).
- No handshake; `en` is level-sensitive and is sampled every edge.

## Test plan

Defaults unless stated: WIDTH=4, MODULUS=10, SATURATE=0.

1. Reset, then en=1, up=1 for 12 cycles → z = 1,2,…,9,0,1,2. ovf high only in the cycle z=0. tc high while z=9.
2. From z=0, en=1, up=0 for 3 cycles → z = 9,8,7. ovf pulses with z=9. tc high in the first cycle (z=0).
3. SATURATE=1: load din=8, then en=1, up=1 for 4 cycles → z = 9,9,9,9. ovf = 0,1,1,1. Then up=0 → z=8, ovf=0.
4. Load din=13 (> MODULUS-1) → z=9. Load din=4 together with en=1 → z=4, no step. clr=1 with load=1, din=6 → z=0.
5. Mid-count at z=5, assert rst for 1 cycle with en=1 → z=0, ovf=0 next cycle. Counting resumes from 0 → 1.
6. Two-instance cascade (low.tc → high.en, both up, MODULUS=10), low.en=1 for 100 cycles from reset → {high,low} = 0,0 after 100 steps. high.ovf pulses once. At cycle 99 z pair = 9,9 with both tc high.
